// File: rtl/spi_target.sv
// SPI mode-0 target (MSB first, 8-bit frames), oversampled in the clk domain.
// Optional SPI_TARGET_ECHO_EN: an empty TX register loads the last received byte instead of IDLE_FILL.
module spi_target #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_FILL   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_ce_n,
  output logic       spi_miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       selected
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BYTE_W);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ce_sync_q, ce_sync_d;
  logic                sck_prev_q, sck_prev_d;
  logic                ce_prev_q, ce_prev_d;
  logic                armed_q, armed_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-2:0]   tx_shift_q, tx_shift_d;
  logic [BYTE_W-1:0]   rx_shift_q, rx_shift_d;
  logic                done_q, done_d;
  logic                miso_q, miso_d;
  logic [BYTE_W-1:0]   tx_buf_q, tx_buf_d;
  logic                tx_ready_q, tx_ready_d;
  logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rx_ovr_q, rx_ovr_d;
  logic                selected_q, selected_d;
`ifdef SPI_TARGET_ECHO_EN
  logic [BYTE_W-1:0]   last_rx_q, last_rx_d;
`endif

  logic              sck_s, mosi_s, ce_s;
  logic              sck_rise, sck_fall, ce_rise, ce_fall;
  logic              do_load;
  logic [BYTE_W-1:0] fill_byte, load_byte;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign ce_s   = ce_sync_q[SYNC_STAGES-1];

  // A frame only starts after CE_n has been seen high since reset.
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ce_rise  = ce_s & ~ce_prev_q;
  assign ce_fall  = ~ce_s & ce_prev_q & armed_q;

  always_comb begin
    state_d     = state_q;
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    ce_sync_d   = {ce_sync_q[SYNC_STAGES-2:0], spi_ce_n};
    sck_prev_d  = sck_s;
    ce_prev_d   = ce_s;
    armed_d     = armed_q | ce_s;
    cnt_d       = cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    done_d      = 1'b0;
    miso_d      = miso_q;
    tx_buf_d    = tx_buf_q;
    tx_ready_d  = tx_ready_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    rx_ovr_d    = rx_ovr_q;
    do_load     = 1'b0;
`ifdef SPI_TARGET_ECHO_EN
    last_rx_d   = last_rx_q;
    fill_byte   = last_rx_q;
`else
    fill_byte   = IDLE_FILL;
`endif
    load_byte   = tx_ready_q ? fill_byte : tx_buf_q;

    if (tx_valid && tx_ready_q) begin
      tx_buf_d   = tx_data;
      tx_ready_d = 1'b0;
    end

    // Completed byte is published one cycle after the 8th rise; a same-cycle ack loses.
    if (done_q) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) rx_ovr_d = 1'b1;
`ifdef SPI_TARGET_ECHO_EN
      last_rx_d  = rx_shift_q;
`endif
    end else if (rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
    end
    if (ce_rise) rx_ovr_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ce_fall) begin
          state_d    = ST_ACTIVE;
          do_load    = 1'b1;
          cnt_d      = '0;
          rx_shift_d = '0;
        end
      end
      ST_ACTIVE: begin
        if (ce_rise) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          rx_shift_d = '0;
          tx_shift_d = '0;
          miso_d     = 1'b1;
        end else if (sck_rise && (cnt_q < FULL_CNT)) begin
          rx_shift_d = {rx_shift_q[BYTE_W-2:0], mosi_s};
          cnt_d      = cnt_q + CNT_W'(1);
          done_d     = (cnt_q == LAST_BIT);
        end else if (sck_fall) begin
          if (cnt_q == FULL_CNT) begin
            do_load = 1'b1;
            cnt_d   = '0;
          end else if (cnt_q != '0) begin
            miso_d     = tx_shift_q[BYTE_W-2];
            tx_shift_d = {tx_shift_q[BYTE_W-3:0], 1'b0};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // miso_q carries the current bit; tx_shift_q holds the bits still to go.
    if (do_load) begin
      miso_d     = load_byte[BYTE_W-1];
      tx_shift_d = load_byte[BYTE_W-2:0];
      if (!tx_ready_q) tx_ready_d = 1'b1;
    end

    selected_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ce_sync_q   <= '0;
      sck_prev_q  <= 1'b0;
      ce_prev_q   <= 1'b0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      done_q      <= 1'b0;
      miso_q      <= 1'b1;
      tx_buf_q    <= '0;
      tx_ready_q  <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_ovr_q    <= 1'b0;
      selected_q  <= 1'b0;
`ifdef SPI_TARGET_ECHO_EN
      last_rx_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ce_sync_q   <= ce_sync_d;
      sck_prev_q  <= sck_prev_d;
      ce_prev_q   <= ce_prev_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      done_q      <= done_d;
      miso_q      <= miso_d;
      tx_buf_q    <= tx_buf_d;
      tx_ready_q  <= tx_ready_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_ovr_q    <= rx_ovr_d;
      selected_q  <= selected_d;
`ifdef SPI_TARGET_ECHO_EN
      last_rx_q   <= last_rx_d;
`endif
    end
  end

  assign spi_miso   = miso_q;
  assign tx_ready   = tx_ready_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_ovr_q;
  assign selected   = selected_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a byte-level model of the target predicts outputs,
// checked every idle cycle by one compare process plus per-byte and literal checks.
module tb_spi_target;

  localparam int unsigned SYNC = 2;
  localparam int unsigned HALF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_ce_n = 1'b1;
  logic       spi_miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       rx_overrun;
  logic       selected;

  spi_target #(.SYNC_STAGES(SYNC), .IDLE_FILL(8'hFF)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_ce_n(spi_ce_n),
    .spi_miso(spi_miso), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack), .rx_overrun(rx_overrun),
    .selected(selected)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  // Byte-level model state
  logic [7:0] exp_rx_data, tx_buf, cur_load, last_rx, last_miso;
  logic       exp_rx_valid, exp_ovr, exp_sel, exp_miso, tx_held;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fill();
`ifdef SPI_TARGET_ECHO_EN
    return last_rx;
`else
    return 8'hFF;
`endif
  endfunction

  task automatic model_reset();
    exp_rx_data = 8'h00; exp_rx_valid = 1'b0; exp_ovr = 1'b0; exp_sel = 1'b0;
    exp_miso = 1'b1; tx_held = 1'b0; tx_buf = 8'h00; cur_load = 8'h00; last_rx = 8'h00;
  endtask

  task automatic model_load();
    if (tx_held) begin
      cur_load = tx_buf;
      tx_held  = 1'b0;
    end else begin
      cur_load = fill();
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rx_data", rx_data, exp_rx_data);
      check("rx_valid", 8'(rx_valid), 8'(exp_rx_valid));
      check("rx_overrun", 8'(rx_overrun), 8'(exp_ovr));
      check("tx_ready", 8'(tx_ready), 8'(!tx_held));
      check("selected", 8'(selected), 8'(exp_sel));
      check("spi_miso", 8'(spi_miso), 8'(exp_miso));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gap();
    tick(HALF);
    chk_en = 1'b1;
    tick(4);
    chk_en = 1'b0;
  endtask

  task automatic offer_tx(input logic [7:0] d);
    tx_data = d; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    if (!tx_held) begin
      tx_buf = d; tx_held = 1'b1;
    end
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    exp_rx_valid = 1'b0;
    check("rx_valid_after_ack", 8'(rx_valid), 8'h00);
  endtask

  task automatic ce_fall();
    spi_ce_n = 1'b0;
    tick(HALF);
    exp_sel = 1'b1;
    model_load();
  endtask

  task automatic ce_rise();
    spi_ce_n = 1'b1;
    tick(HALF);
    exp_sel = 1'b0; exp_ovr = 1'b0; exp_miso = 1'b1;
  endtask

  // mode 0: no ack, 1: ack after the byte, 2: ack in the completion cycle
  task automatic xfer(input logic [7:0] b, input int mode);
    logic [7:0] obs;
    logic [7:0] want;
    want = cur_load;
    obs  = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      tick(HALF);
      obs[i] = spi_miso;
      spi_clk = 1'b1;
      if (i == 0 && mode == 2) begin
        tick(SYNC + 1);
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        tick(HALF - SYNC - 2);
      end else begin
        tick(HALF);
      end
      spi_clk = 1'b0;
    end
    tick(HALF);
    if (mode == 0 && exp_rx_valid) exp_ovr = 1'b1;
    exp_rx_data = b; exp_rx_valid = 1'b1; last_rx = b;
    last_miso = obs;
    check("miso_byte", obs, want);
    check("rx_data_byte", rx_data, b);
    check("rx_valid_byte", 8'(rx_valid), 8'h01);
    check("rx_overrun_byte", 8'(rx_overrun), 8'(exp_ovr));
    model_load();
    if (mode == 1) ack_pulse();
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = 1'($urandom_range(0, 1));
      tick(HALF);
      spi_clk = 1'b1;
      tick(HALF);
      spi_clk = 1'b0;
    end
    tick(HALF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    tick(3);
    rst = 1'b0;
    gap();

    // single byte with a queued TX byte
    offer_tx(8'h3C);
    gap();
    ce_fall();
    xfer(8'hA5, 0);
    ce_rise();
    gap();
    check("lit_miso_3C", last_miso, 8'h3C);
    check("lit_rx_A5", rx_data, 8'hA5);
    ack_pulse();
    gap();

    // three bytes, acked, nothing queued
    ce_fall();
    xfer(8'h01, 1);
`ifdef SPI_TARGET_ECHO_EN
    check("lit_miso_echo0", last_miso, 8'hA5);
`else
    check("lit_miso_fill0", last_miso, 8'hFF);
`endif
    xfer(8'h02, 1);
    xfer(8'h03, 1);
`ifdef SPI_TARGET_ECHO_EN
    check("lit_miso_echo2", last_miso, 8'h02);
`else
    check("lit_miso_fill2", last_miso, 8'hFF);
`endif
    ce_rise();
    gap();

    // overrun, cleared by CE_n rise
    ce_fall();
    xfer(8'h11, 0);
    xfer(8'h22, 0);
    check("lit_overrun_set", 8'(rx_overrun), 8'h01);
    check("lit_rx_22", rx_data, 8'h22);
    ce_rise();
    gap();
    check("lit_overrun_clr", 8'(rx_overrun), 8'h00);
    ack_pulse();
    gap();

    // aborted partial byte, then a full frame
    ce_fall();
    pulses(5);
    ce_rise();
    gap();
    check("lit_partial_no_valid", 8'(rx_valid), 8'h00);
    ce_fall();
    xfer(8'h5A, 0);
    ce_rise();
    gap();
    check("lit_rx_5A", rx_data, 8'h5A);
    ack_pulse();

    // ack coinciding with completion while a byte is pending
    ce_fall();
    xfer(8'h44, 0);
    xfer(8'h77, 2);
    ce_rise();
    gap();
    check("lit_rx_77", rx_data, 8'h77);
    check("lit_valid_77", 8'(rx_valid), 8'h01);
    check("lit_ovr_77", 8'(rx_overrun), 8'h00);
    ack_pulse();

    // reset mid-byte with a TX byte buffered
    ce_fall();
    offer_tx(8'hC3);
    pulses(3);
    spi_clk = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(1);
    model_reset();
    check("rst_miso", 8'(spi_miso), 8'h01);
    check("rst_tx_ready", 8'(tx_ready), 8'h01);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_selected", 8'(selected), 8'h00);
    spi_clk = 1'b0;
    tick(3);
    rst = 1'b0;
    gap();
    pulses(8);
    gap();
    ce_rise();
    gap();
    ce_fall();
    xfer(8'h96, 0);
    ce_rise();
    gap();
    check("lit_rx_96", rx_data, 8'h96);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
